tx_encoder_8b10b: RTL and testbench

Transmit-side 8b/10b encoder with running-disparity (RD) tracking. It takes one byte per BitCLK_10 cycle from the TX framer and produces one registered 10-bit code group per cycle to the serializer. Its output bit layout is identical to what the RX decoder consumes: 6b sub-block `abcdei` in [9:4], 4b sub-block `fghj` in [3:0], with `a` = bit 9. An idle cycle is filled with K28.5 commas.

---
 rtl/tx_encoder_8b10b.sv | 68 ++++++
 tb/tb_tx_encoder_8b10b.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/tx_encoder_8b10b.sv
// tx_encoder_8b10b: 8b/10b transmit encoder with running-disparity tracking, K28.5 fill on idle
// Ports: BitCLK_10 clock; Reset sync active-low; TxParallel_8 {HGF,EDCBA}, TxDataK, TxValid inputs;
//        TxParallel_10 {abcdei,fghj} (a = bit 9), TxRD (disparity after the group), TxCodeErr (illegal K pulse), all registered.
// Macro TX_ENCODER_KCHECK_EN: illegal K requests become K28.5 with a TxCodeErr pulse; otherwise they encode as D.x.y.
module tx_encoder_8b10b (
  input  logic       BitCLK_10,
  input  logic       Reset,
  input  logic [7:0] TxParallel_8,
  input  logic       TxDataK,
  input  logic       TxValid,
  output logic [9:0] TxParallel_10,
  output logic       TxRD,
  output logic       TxCodeErr
);
  // RD- column of the 5b/6b table, entry 31 first
  localparam logic [191:0] C6 = {
    6'b101011, 6'b011110, 6'b101110, 6'b001110, 6'b110110, 6'b010110, 6'b100110, 6'b110011,
    6'b111010, 6'b011010, 6'b101010, 6'b001011, 6'b110010, 6'b010011, 6'b100011, 6'b011011,
    6'b010111, 6'b011100, 6'b101100, 6'b001101, 6'b110100, 6'b010101, 6'b100101, 6'b111001,
    6'b111000, 6'b011001, 6'b101001, 6'b110101, 6'b110001, 6'b101101, 6'b011101, 6'b100111};
  // RD- column of the 3b/4b table (P7 for y=7), entry 7 first
  localparam logic [31:0] C4 = {4'b1110, 4'b0110, 4'b1010, 4'b1101, 4'b1100, 4'b0101, 4'b1001, 4'b1011};
  logic       w_legal, w_err, w_k, w_k28, w_unb6, w_rd6, w_a7, w_unb4, w_rd;
  logic [7:0] w_b;
  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [5:0] w_c6n, w_c6;
  logic [3:0] w_c4n, w_c4;
  always_comb begin
    w_legal = TxParallel_8[4:0] == 5'd28 || TxParallel_8 inside {8'hF7, 8'hFB, 8'hFD, 8'hFE};
`ifdef TX_ENCODER_KCHECK_EN
    w_err = TxValid && TxDataK && !w_legal;
    w_b   = (!TxValid || w_err) ? 8'hBC : TxParallel_8;
    w_k   = !TxValid || TxDataK;
`else
    w_err = 1'b0;
    w_b   = TxValid ? TxParallel_8 : 8'hBC;
    w_k   = !TxValid || (TxDataK && w_legal);
`endif
    w_x    = w_b[4:0];
    w_y    = w_b[7:5];
    w_k28  = w_k && w_x == 5'd28;
    w_c6n  = w_k28 ? 6'b001111 : C6[int'(w_x)*6 +: 6];
    w_unb6 = $countones(w_c6n) != 3;
    // D.7 is balanced but still alternates between 111000 and 000111
    w_c6   = (TxRD && (w_unb6 || w_x == 5'd7)) ? ~w_c6n : w_c6n;
    w_rd6  = TxRD ^ w_unb6;
    // A7 avoids a run of five equal bits across the 6b/4b boundary
    w_a7   = w_k || (w_rd6 ? w_x inside {5'd11, 5'd13, 5'd14} : w_x inside {5'd17, 5'd18, 5'd20});
    w_c4n  = (w_y == 3'd7 && w_a7) ? 4'b0111 : C4[int'(w_y)*4 +: 4];
    w_unb4 = $countones(w_c4n) != 2;
    // K28.1/2/5/6 keep the data code after the RD- 6b group (RD+ here) and invert otherwise
    w_c4   = (w_k28 && w_y inside {3'd1, 3'd2, 3'd5, 3'd6}) ? (w_rd6 ? w_c4n : ~w_c4n)
           : ((w_rd6 && (w_unb4 || w_y == 3'd3)) ? ~w_c4n : w_c4n);
    w_rd   = w_rd6 ^ w_unb4;
  end
  always_ff @(posedge BitCLK_10) begin
    if (!Reset) begin
      TxParallel_10 <= 10'h000;
      TxRD          <= 1'b0;
      TxCodeErr     <= 1'b0;
    end else begin
      TxParallel_10 <= {w_c6, w_c4};
      TxRD          <= w_rd;
      TxCodeErr     <= w_err;
    end
  end
endmodule

// File: tb/tb_tx_encoder_8b10b.sv
// tb_tx_encoder_8b10b: randomized check of tx_encoder_8b10b against a table-driven 8b/10b model
module tb_tx_encoder_8b10b;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       k = 1'b0;
  logic       v = 1'b0;
  logic [9:0] q;
  logic       q_rd, q_err;
  int total = 0;
  int bad = 0;
  logic [9:0] e_code = 10'h000;
  logic       e_rd = 1'b0;
  logic       e_err = 1'b0;
  logic       live = 1'b0;
  logic [5:0] d6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                          6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                          6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] d4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [7:0] kset [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  tx_encoder_8b10b dut (
    .BitCLK_10(clk), .Reset(rst_n), .TxParallel_8(d), .TxDataK(k), .TxValid(v),
    .TxParallel_10(q), .TxRD(q_rd), .TxCodeErr(q_err));

  always #5 clk = ~clk;

  // returns {err, rd_after, code}
  function automatic logic [11:0] enc(input logic vv, input logic kk, input logic [7:0] bb, input logic rd);
    logic err, legal, rd6, a7;
    logic [5:0] six;
    logic [3:0] four;
    int x, y;
    err = 1'b0;
    if (!vv) begin bb = 8'hBC; kk = 1'b1; end
    legal = bb[4:0] == 5'd28 || bb == 8'hF7 || bb == 8'hFB || bb == 8'hFD || bb == 8'hFE;
    if (kk && !legal) begin
`ifdef TX_ENCODER_KCHECK_EN
      bb = 8'hBC; err = 1'b1;
`else
      kk = 1'b0;
`endif
    end
    x = int'(bb[4:0]);
    y = int'(bb[7:5]);
    six = (kk && x == 28) ? 6'b001111 : d6[x];
    rd6 = ($countones(six) == 3) ? rd : ~rd;
    if (rd && ($countones(six) != 3 || x == 7)) six = ~six;
    four = d4[y];
    a7 = kk || (!rd6 && (x == 17 || x == 18 || x == 20)) || (rd6 && (x == 11 || x == 13 || x == 14));
    if (y == 7 && a7) four = 4'b0111;
    if (kk && x == 28 && (y == 1 || y == 2 || y == 5 || y == 6)) begin
      if (rd) four = ~four;
    end else if (rd6 && ($countones(four) != 2 || y == 3)) four = ~four;
    return {err, ($countones(four) == 2) ? rd6 : ~rd6, six, four};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      {e_err, e_rd, e_code} <= 12'h000;
      live <= 1'b0;
    end else begin
      {e_err, e_rd, e_code} <= enc(v, k, d, e_rd);
      live <= 1'b1;
    end
  end

  always @(negedge clk) begin
    total++;
    if ({q_err, q_rd, q} !== {e_err, e_rd, e_code}) begin
      bad++;
      $display("FAIL model t=%0t got code=%h rd=%b err=%b want code=%h rd=%b err=%b", $time, q, q_rd, q_err, e_code, e_rd, e_err);
    end
    if (live) begin
      total++;
      if (!($countones(q) inside {4, 5, 6})) begin
        bad++;
        $display("FAIL balance t=%0t code=%h ones=%0d want 4..6", $time, q, $countones(q));
      end
    end
  end

  task automatic step(input logic vv, input logic kk, input logic [7:0] bb);
    v = vv; k = kk; d = bb;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [9:0] c, input logic r, input logic e);
    total++;
    if ({q_err, q_rd, q} !== {e, r, c}) begin
      bad++;
      $display("FAIL %s got code=%h rd=%b err=%b want code=%h rd=%b err=%b", name, q, q_rd, q_err, c, r, e);
    end
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 8'h55);
    lit("reset", 10'h000, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 8'h00); lit("d0.0_a", 10'h274, 0, 0);
    step(1, 0, 8'h00); lit("d0.0_b", 10'h274, 0, 0);
    step(0, 1, 8'h00); lit("idle_a", 10'h0FA, 1, 0);
    step(0, 0, 8'h37); lit("idle_b", 10'h305, 0, 0);
    step(1, 0, 8'hB5); lit("d21.5_neg", 10'h2AA, 0, 0);
    step(0, 0, 8'h00); lit("idle_c", 10'h0FA, 1, 0);
    step(1, 0, 8'hB5); lit("d21.5_pos", 10'h2AA, 1, 0);
    step(1, 0, 8'hEB); lit("d11.7_pos", 10'h348, 0, 0);
    step(1, 0, 8'hF1); lit("d17.7_neg", 10'h237, 1, 0);
    rst_n = 1'b0;
    step(1, 0, 8'h00); lit("mid_reset", 10'h000, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 8'h00); lit("after_reset", 10'h274, 0, 0);
    step(1, 1, 8'h00);
`ifdef TX_ENCODER_KCHECK_EN
    lit("illegal_k", 10'h0FA, 1, 1);
`else
    lit("illegal_k", 10'h274, 0, 0);
`endif
    step(1, 0, 8'h00);
    total++;
    if (q_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse got err=%b want 0", q_err);
    end
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst_n = ($urandom_range(0, 199) != 0);
      if (r < 10) step(0, 1'($urandom), 8'($urandom));
      else if (r < 30) step(1, 1, kset[$urandom_range(0, 11)]);
      else if (r < 35) step(1, 1, 8'($urandom));
      else step(1, 0, 8'($urandom));
    end
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
